// File: rtl/ip1_test1_rx.sv
`default_nettype none
// ============================================================================
// Module   : ip1_test1_rx
// Purpose  : Receive-side checker for the CONFIG-SHIFT-REG serial loopback
//            test: samples config_out, skips the chain's prior content and
//            compares the rest against the transmit-side expected bit.
// Revision : 1.0 - initial release
// ============================================================================
module ip1_test1_rx #(
    parameter int SKIP_BITS = 768,
    parameter int RX_W      = 32,
    parameter int CNT_W     = 14
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic [6:0]       clk_counter,
    input  logic [6:0]       sample_phase,
    input  logic             rx_start_re,
    input  logic             shift_active,
    input  logic             config_out_i,
    input  logic             exp_bit_i,
    input  logic [CNT_W-1:0] sample_cnt_max,
    output logic [1:0]       rx_state,
    output logic             rx_status_done,
    output logic             rx_status_abort,
    output logic [CNT_W-1:0] rx_sample_cnt,
    output logic [CNT_W-1:0] rx_err_cnt,
    output logic [CNT_W-1:0] rx_first_err_idx,
    output logic [RX_W-1:0]  rx_word
);

    localparam logic [1:0] c_ST_IDLE    = 2'b00;
    localparam logic [1:0] c_ST_ARM     = 2'b01;
    localparam logic [1:0] c_ST_CAPTURE = 2'b10;
    localparam logic [1:0] c_ST_DONE    = 2'b11;

    localparam logic [CNT_W-1:0] c_ALL_ONES = '1;
    localparam logic [CNT_W-1:0] c_SKIP     = CNT_W'(SKIP_BITS);

    logic [1:0]       r_state;
    logic [1:0]       w_state_next;
    logic             r_sync1;
    logic             r_sync2;
    logic             r_done;
    logic             r_abort;
    logic [CNT_W-1:0] r_sample_cnt;
    logic [CNT_W-1:0] r_err_cnt;
    logic [CNT_W-1:0] r_first_err_idx;
    logic [RX_W-1:0]  r_rx_word;

    logic w_sample_evt;
    logic w_last;
    logic w_clear;
    logic w_take;
    logic w_set_done;
    logic w_set_abort;
    logic w_mismatch;

    assign w_sample_evt = (r_state == c_ST_CAPTURE) && (clk_counter == sample_phase);
    assign w_last       = (r_sample_cnt == sample_cnt_max);
    assign w_mismatch   = w_take && (r_sample_cnt >= c_SKIP) && (r_sync2 != exp_bit_i);

    always_comb begin
        w_state_next = r_state;
        w_clear      = 1'b0;
        w_take       = 1'b0;
        w_set_done   = 1'b0;
        w_set_abort  = 1'b0;
        if (!enable) begin
            w_state_next = c_ST_IDLE;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (rx_start_re) begin
                        w_state_next = c_ST_ARM;
                        w_clear      = 1'b1;
                    end
                end
                c_ST_ARM: begin
                    if (rx_start_re) begin
                        w_clear = 1'b1;
                    end else if (shift_active) begin
                        w_state_next = c_ST_CAPTURE;
                    end
                end
                c_ST_CAPTURE: begin
                    // A sample event wins over a simultaneous fall of shift_active.
                    if (w_sample_evt) begin
                        w_take = 1'b1;
                        if (w_last) begin
                            w_state_next = c_ST_DONE;
                            w_set_done   = 1'b1;
                        end
                    end else if (!shift_active) begin
                        w_state_next = c_ST_DONE;
                        w_set_done   = 1'b1;
                        w_set_abort  = 1'b1;
                    end
                end
                c_ST_DONE: w_state_next = c_ST_IDLE;
                default:   w_state_next = c_ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state         <= c_ST_IDLE;
            r_sync1         <= 1'b0;
            r_sync2         <= 1'b0;
            r_done          <= 1'b0;
            r_abort         <= 1'b0;
            r_sample_cnt    <= '0;
            r_err_cnt       <= '0;
            r_first_err_idx <= c_ALL_ONES;
            r_rx_word       <= '0;
        end else begin
            r_state <= w_state_next;
            r_sync1 <= config_out_i;
            r_sync2 <= r_sync1;
            if (w_clear) begin
                r_done          <= 1'b0;
                r_abort         <= 1'b0;
                r_sample_cnt    <= '0;
                r_err_cnt       <= '0;
                r_first_err_idx <= c_ALL_ONES;
                r_rx_word       <= '0;
            end else begin
                if (w_take) begin
                    r_rx_word    <= {r_sync2, r_rx_word[RX_W-1:1]};
                    r_sample_cnt <= r_sample_cnt + 1'b1;
                end
                if (w_mismatch) begin
                    if (r_err_cnt != c_ALL_ONES) begin
                        r_err_cnt <= r_err_cnt + 1'b1;
                    end
                    if (r_err_cnt == '0) begin
                        r_first_err_idx <= r_sample_cnt;
                    end
                end
                if (w_set_done) begin
                    r_done <= 1'b1;
                end
                if (w_set_abort) begin
                    r_abort <= 1'b1;
                end
            end
        end
    end

    assign rx_state         = r_state;
    assign rx_status_done   = r_done;
    assign rx_status_abort  = r_abort;
    assign rx_sample_cnt    = r_sample_cnt;
    assign rx_err_cnt       = r_err_cnt;
    assign rx_first_err_idx = r_first_err_idx;
    assign rx_word          = r_rx_word;

endmodule
`default_nettype wire

// File: tb/tb_ip1_test1_rx.sv
`default_nettype none
// ============================================================================
// Module   : tb_ip1_test1_rx
// Purpose  : Directed, table-driven self-checking bench for ip1_test1_rx.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ip1_test1_rx;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic [6:0]  clk_counter;
    logic [6:0]  sample_phase;
    logic        rx_start_re;
    logic        shift_active;
    logic        config_out_i;
    logic        exp_bit_i;
    logic [13:0] sample_cnt_max;
    logic [1:0]  rx_state;
    logic        rx_status_done;
    logic        rx_status_abort;
    logic [13:0] rx_sample_cnt;
    logic [13:0] rx_err_cnt;
    logic [13:0] rx_first_err_idx;
    logic [31:0] rx_word;

    int total = 0;
    int bad   = 0;

    ip1_test1_rx #(.SKIP_BITS(768), .RX_W(32), .CNT_W(14)) dut (
        .clk              (clk),
        .reset            (reset),
        .enable           (enable),
        .clk_counter      (clk_counter),
        .sample_phase     (sample_phase),
        .rx_start_re      (rx_start_re),
        .shift_active     (shift_active),
        .config_out_i     (config_out_i),
        .exp_bit_i        (exp_bit_i),
        .sample_cnt_max   (sample_cnt_max),
        .rx_state         (rx_state),
        .rx_status_done   (rx_status_done),
        .rx_status_abort  (rx_status_abort),
        .rx_sample_cnt    (rx_sample_cnt),
        .rx_err_cnt       (rx_err_cnt),
        .rx_first_err_idx (rx_first_err_idx),
        .rx_word          (rx_word)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          max_idx;
        int          inv_a;
        int          inv_b;
        int          drop_at;
        bit          alt;
        int          start_mid;
        bit          exp_abort;
        int          exp_cnt;
        int          exp_err;
        int          exp_first;
        bit          chk_word;
        logic [31:0] exp_word;
    } vec_t;

    vec_t vecs[7];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic bit pat(input int k, input bit alt);
        if (alt) return (k % 2) == 0;
        return bit'((((k * 5) / 3) + (k / 7)) % 2);
    endfunction

    // One sample per 3 clks: counter 0,1,2 with sampling at 2. Data is set
    // at counter 0 so it clears the 2-flop synchronizer before the sample edge.
    task automatic run(input int max_idx, input int inv_a, input int inv_b,
                       input int stop_at, input bit alt, input int start_mid);
        sample_cnt_max = 14'(max_idx);
        rx_start_re    = 1'b1;
        clk_counter    = 7'd0;
        tick();
        rx_start_re  = 1'b0;
        shift_active = 1'b1;
        for (int k = 0; k <= max_idx; k++) begin
            if (k == stop_at) break;
            exp_bit_i    = pat(k, alt);
            config_out_i = pat(k, alt) ^ ((k == inv_a) || (k == inv_b));
            clk_counter  = 7'd0;
            tick();
            clk_counter = 7'd1;
            rx_start_re = (k == start_mid);
            tick();
            rx_start_re = 1'b0;
            clk_counter = 7'd2;
            tick();
        end
        clk_counter  = 7'd0;
        shift_active = 1'b0;
    endtask

    initial begin
        reset          = 1'b1;
        enable         = 1'b0;
        clk_counter    = 7'd0;
        sample_phase   = 7'd2;
        rx_start_re    = 1'b0;
        shift_active   = 1'b0;
        config_out_i   = 1'b0;
        exp_bit_i      = 1'b0;
        sample_cnt_max = 14'd0;

        //           max   invA invB drop alt mid abort cnt  err first   chk word
        vecs[0] = '{1535,  -1,  -1,  -1, 0, -1, 0, 1536, 0, 'h3FFF, 0, 32'h0};
        vecs[1] = '{1535, 800, 900,  -1, 0, -1, 0, 1536, 2, 800,    0, 32'h0};
        vecs[2] = '{1535,  10,  -1,  -1, 0, -1, 0, 1536, 0, 'h3FFF, 0, 32'h0};
        vecs[3] = '{1535,  -1,  -1, 100, 0, -1, 1, 100,  0, 'h3FFF, 0, 32'h0};
        vecs[4] = '{39,     5,  -1,  -1, 1, 20, 0, 40,   0, 'h3FFF, 1, 32'h55555555};
        vecs[5] = '{40,    -1,  -1,  -1, 1, -1, 0, 41,   0, 'h3FFF, 1, 32'hAAAAAAAA};
        vecs[6] = '{1000, 767, 768,  -1, 0, -1, 0, 1001, 1, 768,    0, 32'h0};

        repeat (3) tick();
        reset  = 1'b0;
        enable = 1'b1;
        repeat (20) tick();
        check("idle_state", 32'(rx_state), 32'h0);
        check("idle_done", 32'(rx_status_done), 32'h0);
        check("idle_abort", 32'(rx_status_abort), 32'h0);
        check("idle_err", 32'(rx_err_cnt), 32'h0);
        check("idle_first", 32'(rx_first_err_idx), 32'h3FFF);
        check("idle_word", rx_word, 32'h0);

        for (int i = 0; i < 7; i++) begin
            run(vecs[i].max_idx, vecs[i].inv_a, vecs[i].inv_b,
                vecs[i].drop_at, vecs[i].alt, vecs[i].start_mid);
            if (vecs[i].drop_at >= 0) tick();
            check($sformatf("v%0d_state_done", i), 32'(rx_state), 32'h3);
            check($sformatf("v%0d_done", i), 32'(rx_status_done), 32'h1);
            check($sformatf("v%0d_abort", i), 32'(rx_status_abort), 32'(vecs[i].exp_abort));
            check($sformatf("v%0d_cnt", i), 32'(rx_sample_cnt), 32'(vecs[i].exp_cnt));
            check($sformatf("v%0d_err", i), 32'(rx_err_cnt), 32'(vecs[i].exp_err));
            check($sformatf("v%0d_first", i), 32'(rx_first_err_idx), 32'(vecs[i].exp_first));
            if (vecs[i].chk_word) check($sformatf("v%0d_word", i), rx_word, vecs[i].exp_word);
            tick();
            check($sformatf("v%0d_state_idle", i), 32'(rx_state), 32'h0);
            check($sformatf("v%0d_done_hold", i), 32'(rx_status_done), 32'h1);
        end

        // enable low blocks a start pulse and leaves the results untouched
        enable      = 1'b0;
        rx_start_re = 1'b1;
        tick();
        rx_start_re = 1'b0;
        check("en_low_state", 32'(rx_state), 32'h0);
        check("en_low_done", 32'(rx_status_done), 32'h1);
        check("en_low_cnt", 32'(rx_sample_cnt), 32'd1001);
        enable = 1'b1;
        tick();

        // reset in the middle of a capture
        run(1535, -1, -1, 500, 0, -1);
        check("pre_rst_cnt", 32'(rx_sample_cnt), 32'd500);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("rst_state", 32'(rx_state), 32'h0);
        check("rst_done", 32'(rx_status_done), 32'h0);
        check("rst_abort", 32'(rx_status_abort), 32'h0);
        check("rst_cnt", 32'(rx_sample_cnt), 32'h0);
        check("rst_err", 32'(rx_err_cnt), 32'h0);
        check("rst_first", 32'(rx_first_err_idx), 32'h3FFF);
        check("rst_word", rx_word, 32'h0);
        tick();
        run(1535, -1, -1, -1, 0, -1);
        check("rearm_state", 32'(rx_state), 32'h3);
        check("rearm_done", 32'(rx_status_done), 32'h1);
        check("rearm_abort", 32'(rx_status_abort), 32'h0);
        check("rearm_cnt", 32'(rx_sample_cnt), 32'd1536);
        check("rearm_err", 32'(rx_err_cnt), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
